// File: rtl/light_pkg.sv
// Shared light codes, controller state encoding and the per-road light helper
// used by the multi-approach intersection controller.
package light_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } light_t;

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2
  } state_t;

  // Light shown by one road given the controller state and the owning road.
  function automatic light_t road_light(state_t st, int unsigned cur, int unsigned road);
    light_t code;
    code = RED;
    if (road == cur) begin
      if (st == S_GREEN) begin
        code = GREEN;
      end else if (st == S_YELLOW) begin
        code = YELLOW;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/multi_road_ctrl_if.sv
// Sensor/light bundle between the intersection controller and its roads.
// The controller side uses the master modport.
interface multi_road_ctrl_if #(
  parameter int N_ROADS = 4,
  parameter int IDX_W   = $clog2(N_ROADS)
);
  logic [N_ROADS-1:0]   car_on;
  logic [2*N_ROADS-1:0] light;
  logic [IDX_W-1:0]     phase_id;
  logic                 phase_start;
  logic [N_ROADS-1:0]   demand;

  modport master (
    input  car_on,
    output light,
    output phase_id,
    output phase_start,
    output demand
  );

  modport slave (
    output car_on,
    input  light,
    input  phase_id,
    input  phase_start,
    input  demand
  );
endinterface

// File: rtl/rr_next_sel.sv
// Round-robin pick of the next demanded road after cur; returns road 0 and
// found=0 when no other road has demand.
module rr_next_sel #(
  parameter int N_ROADS = 4,
  parameter int IDX_W   = $clog2(N_ROADS)
) (
  input  logic [N_ROADS-1:0] demand,
  input  logic [IDX_W-1:0]   cur,
  output logic [IDX_W-1:0]   nxt,
  output logic               found
);
  logic [IDX_W-1:0]   cand_idx [1:N_ROADS-1];
  logic [N_ROADS-1:1] cand_dem;

  for (genvar gi = 1; gi < N_ROADS; gi++) begin : g_cand
    assign cand_idx[gi] = IDX_W'((int'(cur) + gi) % N_ROADS);
    assign cand_dem[gi] = demand[cand_idx[gi]];
  end

  // Scan farthest first so the closest demanded road after cur wins.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int k = N_ROADS - 1; k >= 1; k--) begin
      if (cand_dem[k]) begin
        nxt   = cand_idx[k];
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/multi_road_ctrl.sv
// N-approach intersection controller: road 0 rests green, other roads are
// served round-robin with min/max green, yellow and all-red intervals.
module multi_road_ctrl
  import light_pkg::*;
#(
  parameter int N_ROADS   = 4,
  parameter int IDX_W     = $clog2(N_ROADS),
  parameter int CNT_W     = 8,
  parameter int MIN_GREEN = 10,
  parameter int MAX_GREEN = 40,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2
) (
  input logic               clk,
  input logic               rst,
  multi_road_ctrl_if.master bus
);
  localparam logic [CNT_W-1:0] MIN_M1    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_M1    = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_M1    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_M1     = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] TIMER_SAT = {CNT_W{1'b1}};
  localparam logic [2*N_ROADS-1:0] LIGHT_RST = {{(2*N_ROADS-2){1'b0}}, GREEN};

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     cur_reg, cur_next;
  logic [IDX_W-1:0]     nxt_reg, nxt_next;
  logic [CNT_W-1:0]     timer_reg, timer_next;
  logic [N_ROADS-1:0]   demand_reg, demand_next;
  logic [2*N_ROADS-1:0] light_reg, light_next;
  logic [IDX_W-1:0]     phase_id_reg, phase_id_next;
  logic                 phase_start_reg, phase_start_next;

  logic [N_ROADS-1:0] cur_onehot, nxt_onehot, green_mask, demand_set;
  logic               other_dem, car_cur, exit_green;
  logic [IDX_W-1:0]   sel_nxt;
  logic               sel_found;

  rr_next_sel #(
    .N_ROADS(N_ROADS),
    .IDX_W  (IDX_W)
  ) u_rr_next_sel (
    .demand(demand_reg),
    .cur   (cur_reg),
    .nxt   (sel_nxt),
    .found (sel_found)
  );

  for (genvar gi = 0; gi < N_ROADS; gi++) begin : g_road
    assign cur_onehot[gi] = (cur_reg == IDX_W'(gi));
    assign nxt_onehot[gi] = (nxt_reg == IDX_W'(gi));
    assign green_mask[gi] = (state_reg == S_GREEN) && cur_onehot[gi];
    // Lights are built from the next state so the bus is a plain register.
    assign light_next[2*gi +: 2] = road_light(state_next, 32'(cur_next), gi);
  end

  assign demand_set = demand_reg | (bus.car_on & ~green_mask);
  assign other_dem  = |(demand_reg & ~cur_onehot);
  assign car_cur    = bus.car_on[cur_reg];
  assign exit_green = (timer_reg >= MIN_M1) &&
                      ((other_dem && (!car_cur || timer_reg >= MAX_M1)) ||
                       (cur_reg != '0 && demand_reg == '0 && !car_cur));

  always_comb begin
    state_next       = state_reg;
    cur_next         = cur_reg;
    nxt_next         = nxt_reg;
    timer_next       = (timer_reg == TIMER_SAT) ? timer_reg : timer_reg + 1'b1;
    demand_next      = demand_set;
    phase_start_next = 1'b0;
    case (state_reg)
      S_GREEN: begin
        if (exit_green) begin
          state_next = S_YELLOW;
          timer_next = '0;
          nxt_next   = sel_found ? sel_nxt : '0;
        end
      end
      S_YELLOW: begin
        if (timer_reg >= YEL_M1) begin
          state_next = S_ALLRED;
          timer_next = '0;
        end
      end
      S_ALLRED: begin
        if (timer_reg >= AR_M1) begin
          state_next       = S_GREEN;
          timer_next       = '0;
          cur_next         = nxt_reg;
          phase_start_next = 1'b1;
          // Entry clear takes priority over a same-cycle sensor set.
          demand_next      = demand_set & ~nxt_onehot;
        end
      end
      default: begin
        state_next = S_GREEN;
        timer_next = '0;
      end
    endcase
    phase_id_next = (state_next == S_ALLRED) ? nxt_next : cur_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_GREEN;
      cur_reg         <= '0;
      nxt_reg         <= '0;
      timer_reg       <= '0;
      demand_reg      <= '0;
      light_reg       <= LIGHT_RST;
      phase_id_reg    <= '0;
      phase_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cur_reg         <= cur_next;
      nxt_reg         <= nxt_next;
      timer_reg       <= timer_next;
      demand_reg      <= demand_next;
      light_reg       <= light_next;
      phase_id_reg    <= phase_id_next;
      phase_start_reg <= phase_start_next;
    end
  end

  assign bus.light       = light_reg;
  assign bus.phase_id    = phase_id_reg;
  assign bus.phase_start = phase_start_reg;
  assign bus.demand      = demand_reg;
endmodule
